// File: rtl/powlib_lvlfifo.sv
// rtl/powlib_lvlfifo.sv - single-clock valid/ready FIFO with level, nearly-full/empty flags, flush and optional output register
module powlib_lvlfifo #(
  parameter int    W    = 16,
  parameter int    D    = 8,
  parameter int    OREG = 0,
  parameter int    NFS  = 0,
  parameter int    NES  = 0,
  parameter int    EDBG = 0,
  parameter string ID   = "LVLFIFO",
  localparam int   CAP  = D + OREG,
  localparam int   LW   = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic          wrnf,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy,
  output logic          rdne,
  output logic [LW-1:0] lvl
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  // Illegal parameter sets stop elaboration with the instance identifier.
  if (D < 2) begin : g_bad_depth
    $fatal(1, "%s: D must be at least 2", ID);
  end
  if (NFS < 0 || NFS >= CAP) begin : g_bad_nfs
    $fatal(1, "%s: NFS must lie in 0..CAP-1", ID);
  end
  if (NES < 0 || NES >= CAP) begin : g_bad_nes
    $fatal(1, "%s: NES must lie in 0..CAP-1", ID);
  end
  if (OREG < 0 || OREG > 1 || EDBG < 0 || EDBG > 1) begin : g_bad_flags
    $fatal(1, "%s: OREG and EDBG must be 0 or 1", ID);
  end

  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wrptr;
  logic [PW-1:0] r_rdptr;
  logic [CW-1:0] r_ram_cnt;
  logic [LW-1:0] r_lvl;

  logic w_wrinc;
  logic w_rdinc;
  logic w_ramrd;
  logic w_ram_ne;

  // Pointers wrap explicitly at D-1 so non-power-of-2 depths use every slot.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Write readiness only looks at RAM occupancy, never at the read side.
  assign wrrdy    = (r_ram_cnt < CW'(D));
  assign w_ram_ne = (r_ram_cnt != '0);
  assign w_wrinc  = wrvld & wrrdy;
  assign w_rdinc  = rdvld & rdrdy;

  if (OREG != 0) begin : g_oreg
    logic [W-1:0] r_odata;
    logic         r_ovld;

    // RAM head moves into the output register whenever that register is free or being drained.
    assign w_ramrd = w_ram_ne & (~r_ovld | w_rdinc);
    assign rdvld   = r_ovld;
    assign rddata  = r_odata;

    // Output register: refill from RAM, otherwise drop validity once consumed.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_ovld  <= 1'b0;
        r_odata <= '0;
      end else if (clr) begin
        r_ovld  <= 1'b0;
      end else if (w_ramrd) begin
        r_ovld  <= 1'b1;
        r_odata <= r_mem[r_rdptr];
      end else if (w_rdinc) begin
        r_ovld  <= 1'b0;
      end
    end
  end else begin : g_fwft
    // First-word fall-through: the RAM head is presented directly.
    assign w_ramrd = w_rdinc;
    assign rdvld   = w_ram_ne;
    assign rddata  = r_mem[r_rdptr];
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wrinc && !clr) begin
      r_mem[r_wrptr] <= wrdata;
    end
  end

  // Pointer and RAM occupancy bookkeeping; flush wins over any same-cycle transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrptr   <= '0;
      r_rdptr   <= '0;
      r_ram_cnt <= '0;
    end else if (clr) begin
      r_wrptr   <= '0;
      r_rdptr   <= '0;
      r_ram_cnt <= '0;
    end else begin
      if (w_wrinc) begin
        r_wrptr <= f_next(r_wrptr);
      end
      if (w_ramrd) begin
        r_rdptr <= f_next(r_rdptr);
      end
      case ({w_wrinc, w_ramrd})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
    end
  end

  // Total level counts words accepted in minus words handed out, including the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl <= '0;
    end else if (clr) begin
      r_lvl <= '0;
    end else begin
      case ({w_wrinc, w_rdinc})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

  assign lvl  = r_lvl;
  assign wrnf = (r_lvl >= LW'(CAP - NFS));
  assign rdne = (r_lvl <= LW'(NES));

endmodule

// File: tb/tb_powlib_lvlfifo.sv
// tb/tb_powlib_lvlfifo.sv - randomized and directed bench for powlib_lvlfifo against a sequence-number reference model
module tb_powlib_lvlfifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] wrdata = '0;
  logic       wrvld = 1'b0;
  logic       rdrdy = 1'b0;

  logic       wrrdy0, wrnf0, rdvld0, rdne0;
  logic [7:0] rddata0;
  logic [2:0] lvl0;
  logic       wrrdy1, wrnf1, rdvld1, rdne1;
  logic [7:0] rddata1;
  logic [2:0] lvl1;

  int n_chk = 0;
  int n_err = 0;

  // Model: every accepted word gets a sequence number; FIFO content is seq[rc .. wc-1].
  int         wc [2];
  int         rc [2];
  bit         ov [2];
  logic [7:0] seq0 [4096];
  logic [7:0] seq1 [4096];
  int         md [2];
  int         mo [2];
  int         mnfs [2];
  int         mnes [2];

  powlib_lvlfifo #(.W(8), .D(5), .OREG(0), .NFS(0), .NES(0), .EDBG(0), .ID("F0")) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy0),
    .wrnf(wrnf0), .rddata(rddata0), .rdvld(rdvld0), .rdrdy(rdrdy), .rdne(rdne0), .lvl(lvl0)
  );

  powlib_lvlfifo #(.W(8), .D(4), .OREG(1), .NFS(1), .NES(1), .EDBG(0), .ID("F1")) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy1),
    .wrnf(wrnf1), .rddata(rddata1), .rdvld(rdvld1), .rdrdy(rdrdy), .rdne(rdne1), .lvl(lvl1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] head(input int k);
    return (k == 0) ? seq0[rc[0] % 4096] : seq1[rc[1] % 4096];
  endfunction

  task automatic check_outs();
    for (int k = 0; k < 2; k++) begin
      int L;
      int cap;
      int e_vld;
      int o_lvl, o_rdy, o_vld, o_nf, o_ne, o_dat;
      L     = wc[k] - rc[k];
      cap   = md[k] + mo[k];
      e_vld = (mo[k] != 0) ? int'(ov[k]) : int'(L != 0);
      if (k == 0) begin
        o_lvl = lvl0; o_rdy = wrrdy0; o_vld = rdvld0; o_nf = wrnf0; o_ne = rdne0; o_dat = rddata0;
      end else begin
        o_lvl = lvl1; o_rdy = wrrdy1; o_vld = rdvld1; o_nf = wrnf1; o_ne = rdne1; o_dat = rddata1;
      end
      check($sformatf("lvl%0d", k), o_lvl, L);
      check($sformatf("wrrdy%0d", k), o_rdy, int'((L - int'(ov[k])) < md[k]));
      check($sformatf("rdvld%0d", k), o_vld, e_vld);
      check($sformatf("wrnf%0d", k), o_nf, int'(L >= cap - mnfs[k]));
      check($sformatf("rdne%0d", k), o_ne, int'(L <= mnes[k]));
      if (e_vld != 0) check($sformatf("rddata%0d", k), o_dat, int'(head(k)));
    end
  endtask

  task automatic model_flush();
    for (int k = 0; k < 2; k++) begin
      rc[k] = wc[k];
      ov[k] = 1'b0;
    end
  endtask

  // Advance the reference by one clock edge using the inputs presented in that cycle.
  task automatic model_step();
    if (clr) begin
      model_flush();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int  L, rcnt;
      bit  wr, vld, rd, ld;
      L    = wc[k] - rc[k];
      rcnt = L - int'(ov[k]);
      wr   = wrvld && (rcnt < md[k]);
      vld  = (mo[k] != 0) ? ov[k] : (L != 0);
      rd   = vld && rdrdy;
      ld   = (mo[k] != 0) && (rcnt != 0) && (!ov[k] || rd);
      if (rd) rc[k]++;
      if (mo[k] != 0) ov[k] = ld ? 1'b1 : (rd ? 1'b0 : ov[k]);
      if (wr) begin
        if (k == 0) seq0[wc[0] % 4096] = wrdata;
        else        seq1[wc[1] % 4096] = wrdata;
        wc[k]++;
      end
    end
  endtask

  task automatic cyc(input bit wv, input logic [7:0] wd, input bit rr, input bit cl);
    wrvld  = wv;
    wrdata = wd;
    rdrdy  = rr;
    clr    = cl;
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    md   = '{5, 4};
    mo   = '{0, 1};
    mnfs = '{0, 1};
    mnes = '{0, 1};
    wc   = '{0, 0};
    rc   = '{0, 0};
    ov   = '{0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_lvl0", lvl0, 0);
    check("rst_wrrdy0", wrrdy0, 1);
    check("rst_rdne0", rdne0, 1);
    check("rst_wrnf0", wrnf0, 0);
    check("rst_rdvld1", rdvld1, 0);
    check("rst_rddata1", rddata1, 0);
    rst = 1'b1;

    // Fill with rdrdy low; the sixth write must be refused by the 5-deep FIFO
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    check("fill_lvl0", lvl0, 5);
    check("fill_wrrdy0", wrrdy0, 0);
    check("fill_wrnf0", wrnf0, 1);
    check("fill_lvl1", lvl1, 5);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_rdvld0", rdvld0, 0);

    // Streaming with both sides active: pointers wrap without a bubble
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    check("stream_lvl0", lvl0, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Full FIFO with same-cycle read and write: read wins, write lands next cycle
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h70, 1'b1, 1'b0);
    check("fullrw_lvl0", lvl0, 4);
    cyc(1'b1, 8'h70, 1'b0, 1'b0);
    check("fullrw_lvl0b", lvl0, 5);

    // Flush with a concurrent write and read discards both
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b1);
    check("clr_lvl0", lvl0, 0);
    check("clr_rdvld0", rdvld0, 0);
    check("clr_rdne0", rdne0, 1);
    check("clr_lvl1", lvl1, 0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check("clr_aa0", rddata0, 8'hAA);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_aa1", rddata1, 8'hAA);
    check("clr_vld1", rdvld1, 1);

    // Asynchronous reset mid-cycle after loading
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    wrvld = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("arst_lvl0", lvl0, 0);
    check("arst_rdvld0", rdvld0, 0);
    check("arst_wrrdy0", wrrdy0, 1);
    check("arst_lvl1", lvl1, 0);
    check("arst_rdvld1", rdvld1, 0);
    check("arst_rddata1", rddata1, 0);
    model_flush();
    #1 rst = 1'b1;
    cyc(1'b1, 8'hC5, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("arst_first0", rddata0, 8'hC5);
    check("arst_first1", rddata1, 8'hC5);

    // Randomized traffic with phases of biased write/read pressure and rare flushes
    for (int p = 0; p < 6; p++) begin
      int wbias;
      int rbias;
      wbias = $urandom_range(1, 7);
      rbias = $urandom_range(1, 7);
      for (int i = 0; i < 400; i++) begin
        cyc($urandom_range(0, 7) < wbias, 8'($urandom), $urandom_range(0, 7) < rbias,
            $urandom_range(0, 99) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
